ek_modcheck_writer: RTL and testbench
=====================================

# ek_modcheck_writer

Downstream consumer of the ByteDecode12 stage. Takes decoded coefficient pairs (dout_1/dout_2 plus pair index) for the t̂ part of an ML-KEM encapsulation key. Checks each coefficient against q = 3329 (FIPS 203 modulus check) and checks that pair indices arrive in order. Writes each pair as one packed word into the polynomial RAM and reports pass/fail once all K·128 pairs are in.

## Interface
- K, default 3: module rank; sets the pair count as NPAIRS = 128·K.
- Q, default 3329: modulus used by the range check.
- AW, default 9: RAM address width; must satisfy 2^AW ≥ NPAIRS.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; clears counters and flags, enters RUN.
- in_valid  in  1  the pair on coef_a/coef_b/in_index is valid this cycle.
- coef_a  in  16  first coefficient of the pair (decoder dout_1).
- coef_b  in  16  second coefficient of the pair (decoder dout_2).
- in_index  in  16  pair index as produced by the decoder.
- in_ready  out  1  high when a pair can be accepted.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  AW  RAM word address, equal to the pair number.
- mem_wdata  out  24  packed word {coef_b[11:0], coef_a[11:0]}.
- bad_count  out  10  number of out-of-range coefficients seen.
- idx_err  out  1  sticky flag: an index mismatch occurred.
- busy  out  1  high when the state is RUN.
- done  out  1  one-cycle pulse marking completion.
- ek_ok  out  1  pass/fail; valid from done onward until the next start.

## Operation
- States are IDLE, RUN and DONE. The reset state is IDLE.
- Reset values: every output is 0, including in_ready, mem_we, mem_addr, mem_wdata, bad_count, idx_err, busy, done and ek_ok.
- Internal counter: expected pair number `cnt`, width AW.
- IDLE:
  - start → RUN; cnt, bad_count and idx_err clear to 0; ek_ok clears to 0.
  - in_valid is ignored.
- RUN:
  - in_ready = 1.
  - A pair is accepted when in_valid & in_ready.
  - On accept, mem_we, mem_addr = cnt and mem_wdata are registered.
  - cnt increments on each accept.
- Range rule, applied to each coefficient:
  - bad iff c[15:12] ≠ 0 or c[11:0] ≥ Q.
  - bad_count += (bad_a + bad_b) on each accept, so the increment is 0, 1 or 2.
  - Maximum value is 768, which fits in 10 bits; no saturation logic.
- Index rule: in_index ≠ {zero-extended cnt} on accept → set idx_err.
  - The pair is still written at mem_addr = cnt, not at in_index.
- The accept with cnt = NPAIRS−1 moves the state to DONE.
- DONE:
  - done = 1 and ek_ok = (bad_count == 0) & ~idx_err.
  - Next cycle: state → IDLE and done → 0.
  - ek_ok, bad_count and idx_err hold their values until the next start.
- start in RUN or DONE: restarts immediately and has priority over a concurrent accept; the pair on that cycle is dropped and mem_we = 0.
- mem_we is 0 in every cycle without an accept. mem_addr and mem_wdata hold their last values.

## Timing
- Accept at edge E → mem_we/mem_addr/mem_wdata visible in the cycle after E, for exactly one cycle.
- bad_count and idx_err reflect the pair accepted at E from the cycle after E.
- Final accept at edge E: the last write is visible after E (state = DONE); done and ek_ok are visible in that same cycle.
- Full stream: start at edge S, then in_valid held high from the cycle after S. The last write and done occur NPAIRS+1 cycles after S.
- Gaps in in_valid stall cnt with no side effects.
- Reset mid-operation: outputs drop to reset values asynchronously; any pair in flight is lost.

## Structure
- Shared package kyber_pkg holds:
  - KYBER_N = 256 and KYBER_Q = 3329.
  - The default K.
  - The state encoding IDLE/RUN/DONE (2 bits).
  - The packed-word width constant of 24.
- Natural sub-module: coef_lt_q. It is combinational, takes a 16-bit coefficient and Q, and outputs bad. It is instantiated twice.

## Test plan
- All-zero pairs, K=3, 384 contiguous pairs with in_index 0..383:
  - 384 writes with addresses 0..383.
  - mem_wdata = 0.
  - done arrives 385 cycles after start, with ek_ok = 1 and bad_count = 0.
- Boundary values:
  - Pair 5 = (3328, 3329) → mem_wdata[5] = 0xD01D00, bad_count = 1, ek_ok = 0.
  - Pair 6 = (0x1000, 0xFFFF) → bad_count = 3.
- Index error: in_index sequence skips from 9 to 11 → idx_err = 1 from the cycle after that accept, address still 10, final ek_ok = 0.
- Valid gaps: in_valid toggled 1-0-1-0 → writes occur only on accepted cycles, addresses stay contiguous, 384 writes total.
- Restart: start pulsed at pair 100 with in_valid high → no write that cycle, bad_count = 0, the next accept is written to address 0.
- Reset: reset asserted mid-RUN at pair 200 → all outputs go to 0 at once, state is IDLE, in_valid is ignored until the next start.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared ML-KEM constants and the encapsulation-key writer state encoding.
package kyber_pkg;

  localparam int KYBER_N         = 256;
  localparam int KYBER_Q         = 3329;
  localparam int KYBER_K_DEFAULT = 3;
  localparam int EK_WORD_W       = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/coef_lt_q.sv
// Combinational modulus check: flags a 16-bit coefficient that is not a
// canonical residue, i.e. has any of bits [15:12] set or is at least q.
module coef_lt_q (
  input  logic [15:0] coef,
  input  logic [15:0] q,
  output logic        bad
);

  assign bad = (coef[15:12] != 4'd0) || ({4'd0, coef[11:0]} >= q);

endmodule

// File: rtl/ek_modcheck_writer.sv
// Consumes decoded t-hat coefficient pairs, range-checks each coefficient
// against q, checks pair ordering, writes packed pairs into the polynomial
// RAM and reports pass/fail once all K*128 pairs have been accepted.
module ek_modcheck_writer
  import kyber_pkg::*;
#(
  parameter int K  = KYBER_K_DEFAULT,
  parameter int Q  = KYBER_Q,
  parameter int AW = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [15:0]          coef_a,
  input  logic [15:0]          coef_b,
  input  logic [15:0]          in_index,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [EK_WORD_W-1:0] mem_wdata,
  output logic [9:0]           bad_count,
  output logic                 idx_err,
  output logic                 busy,
  output logic                 done,
  output logic                 ek_ok
);

  localparam int             NPAIRS = K * KYBER_N / 2;
  localparam logic [AW-1:0]  LAST   = AW'(NPAIRS - 1);
  localparam logic [15:0]    Q16    = 16'(Q);

  state_e                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic                   mem_we_q, mem_we_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [EK_WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [9:0]             bad_count_q, bad_count_d;
  logic                   idx_err_q, idx_err_d;
  logic                   ek_ok_q, ek_ok_d;
  logic                   bad_a, bad_b;

  coef_lt_q u_chk_a (.coef(coef_a), .q(Q16), .bad(bad_a));
  coef_lt_q u_chk_b (.coef(coef_b), .q(Q16), .bad(bad_b));

  // Next-state and next-value logic; start outranks any concurrent accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bad_count_d = bad_count_q;
    idx_err_d   = idx_err_q;
    ek_ok_d     = ek_ok_q;

    if (start) begin
      state_d     = ST_RUN;
      cnt_d       = '0;
      bad_count_d = '0;
      idx_err_d   = 1'b0;
      ek_ok_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (in_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q;
            mem_wdata_d = {coef_b[11:0], coef_a[11:0]};
            bad_count_d = bad_count_q + 10'(bad_a) + 10'(bad_b);
            idx_err_d   = idx_err_q | (in_index != 16'(cnt_q));
            cnt_d       = cnt_q + AW'(1);
            if (cnt_q == LAST) begin
              state_d = ST_DONE;
              ek_ok_d = (bad_count_d == 10'd0) & ~idx_err_d;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bad_count_q <= '0;
      idx_err_q   <= 1'b0;
      ek_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bad_count_q <= bad_count_d;
      idx_err_q   <= idx_err_d;
      ek_ok_q     <= ek_ok_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bad_count = bad_count_q;
  assign idx_err   = idx_err_q;
  assign ek_ok     = ek_ok_q;

endmodule

// File: tb/tb_ek_modcheck_writer.sv
// Self-checking bench for ek_modcheck_writer: boundary table, directed
// multi-cycle sequences and randomized streams against a behavioural model.
module tb_ek_modcheck_writer;

  localparam int K      = 3;
  localparam int Q      = 3329;
  localparam int AW     = 9;
  localparam int NPAIRS = 128 * K;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [15:0]   coef_a, coef_b, in_index;
  logic          in_ready, mem_we, idx_err, busy, done, ek_ok;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic [9:0]    bad_count;

  ek_modcheck_writer #(.K(K), .Q(Q), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .coef_a(coef_a), .coef_b(coef_b), .in_index(in_index),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .bad_count(bad_count), .idx_err(idx_err),
    .busy(busy), .done(done), .ek_ok(ek_ok)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: "running" session, pairs received, totals.
  bit m_run, m_done, m_we, m_idxerr, m_ok;
  int m_cnt, m_bad, m_addr, m_wdata;

  int cyc, done_cyc, nwrites;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [23:0] wdata;
    int          bad;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_we = 0; m_idxerr = 0; m_ok = 0;
    m_cnt = 0; m_bad = 0; m_addr = 0; m_wdata = 0;
  endfunction

  function automatic void model_edge();
    m_we = 0;
    if (start) begin
      m_run = 1; m_done = 0; m_cnt = 0; m_bad = 0; m_idxerr = 0; m_ok = 0;
    end else if (m_run && in_valid) begin
      m_we    = 1;
      m_addr  = m_cnt;
      m_wdata = (int'(coef_b) % 4096) * 4096 + (int'(coef_a) % 4096);
      m_bad   = m_bad + ((int'(coef_a) >= Q) ? 1 : 0) + ((int'(coef_b) >= Q) ? 1 : 0);
      if (int'(in_index) != m_cnt) m_idxerr = 1;
      m_cnt++;
      if (m_cnt == NPAIRS) begin
        m_run  = 0;
        m_done = 1;
        m_ok   = (m_bad == 0) && !m_idxerr;
      end
    end else if (m_done) begin
      m_done = 0;
    end
  endfunction

  task automatic check_all();
    chk("in_ready",  32'(in_ready),  32'(m_run));
    chk("busy",      32'(busy),      32'(m_run));
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("bad_count", 32'(bad_count), 32'(m_bad));
    chk("idx_err",   32'(idx_err),   32'(m_idxerr));
    chk("done",      32'(done),      32'(m_done));
    chk("ek_ok",     32'(ek_ok),     32'(m_ok));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    cyc++;
    if (mem_we === 1'b1) nwrites++;
    if (done === 1'b1) done_cyc = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc = 0; done_cyc = -1; nwrites = 0;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int idx);
    in_valid = 1'b1;
    coef_a = 16'(a); coef_b = 16'(b); in_index = 16'(idx);
    step();
    in_valid = 1'b0;
  endtask

  function automatic int rgood();
    return int'($urandom_range(0, Q - 1));
  endfunction

  initial begin
    tbl[0] = '{16'd0,      16'd0,      24'h000000, 0};
    tbl[1] = '{16'd1,      16'd2,      24'h002001, 0};
    tbl[2] = '{16'd3328,   16'd3328,   24'hD00D00, 0};
    tbl[3] = '{16'h0ABC,   16'h0123,   24'h123ABC, 0};
    tbl[4] = '{16'd7,      16'd0,      24'h000007, 0};
    tbl[5] = '{16'd3328,   16'd3329,   24'hD01D00, 1};
    tbl[6] = '{16'h1000,   16'hFFFF,   24'hFFF000, 3};
    tbl[7] = '{16'd3329,   16'd4095,   24'hFFFD01, 5};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    coef_a = '0; coef_b = '0; in_index = '0;
    model_reset();
    cyc = 0; done_cyc = -1; nwrites = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;

    // IDLE ignores in_valid.
    for (int i = 0; i < 3; i++) send(5, 6, i);

    // All-zero contiguous stream.
    pulse_start();
    for (int i = 0; i < NPAIRS; i++) send(0, 0, i);
    chk("zero_done_cycle", 32'(done_cyc), 32'(NPAIRS + 1));
    chk("zero_writes",     32'(nwrites),  32'(NPAIRS));
    chk("zero_ek_ok",      32'(ek_ok),    32'd1);
    chk("zero_last_addr",  32'(mem_addr), 32'(NPAIRS - 1));
    step();
    step();

    // Boundary table at the head of a stream.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(int'(tbl[i].a), int'(tbl[i].b), i);
      chk("tbl_we",    32'(mem_we),    32'd1);
      chk("tbl_addr",  32'(mem_addr),  32'(i));
      chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].wdata));
      chk("tbl_bad",   32'(bad_count), 32'(tbl[i].bad));
    end
    for (int i = 8; i < NPAIRS; i++) send(rgood(), rgood(), i);
    chk("tbl_ek_ok", 32'(ek_ok),     32'd0);
    chk("tbl_final", 32'(bad_count), 32'd5);
    step();

    // Index skip 9 -> 11.
    pulse_start();
    for (int i = 0; i < NPAIRS; i++) begin
      send(rgood(), rgood(), (i >= 10) ? i + 1 : i);
      if (i == 9)  chk("idx_before", 32'(idx_err), 32'd0);
      if (i == 10) begin
        chk("idx_set",  32'(idx_err),  32'd1);
        chk("idx_addr", 32'(mem_addr), 32'd10);
      end
    end
    chk("idx_ek_ok", 32'(ek_ok), 32'd0);
    step();

    // Valid gaps with occasional out-of-range coefficients.
    pulse_start();
    begin
      int i = 0;
      int t = 0;
      while (i < NPAIRS && t < 4 * NPAIRS) begin
        t++;
        if (t % 2 == 1) begin
          int a = rgood();
          int b = rgood();
          if ($urandom_range(0, 15) == 0) a = int'($urandom_range(Q, 65535));
          if ($urandom_range(0, 15) == 0) b = int'($urandom_range(Q, 65535));
          send(a, b, i);
          i++;
        end else begin
          coef_a = 16'($urandom); coef_b = 16'($urandom);
          step();
        end
      end
    end
    chk("gap_writes", 32'(nwrites), 32'(NPAIRS));
    chk("gap_done",   32'(done),    32'd1);
    step();

    // Restart at pair 100 with in_valid high.
    pulse_start();
    for (int i = 0; i < 100; i++) send((i == 3) ? 4000 : rgood(), rgood(), i);
    chk("rst_pre_bad", 32'(bad_count), 32'd1);
    in_valid = 1'b1; coef_a = 16'd11; coef_b = 16'd22; in_index = 16'd100;
    pulse_start();
    in_valid = 1'b0;
    chk("restart_we",  32'(mem_we),    32'd0);
    chk("restart_bad", 32'(bad_count), 32'd0);
    send(33, 44, 0);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("restart_we1",  32'(mem_we),   32'd1);
    for (int i = 1; i < NPAIRS; i++) send(rgood(), rgood(), i);
    chk("restart_ok", 32'(ek_ok), 32'd1);
    step();

    // Asynchronous reset mid-RUN at pair 200.
    pulse_start();
    for (int i = 0; i < 200; i++) send(rgood(), (i == 7) ? 5000 : rgood(), i);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("areset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) send(1, 2, 200 + i);
    chk("post_reset_writes", 32'(mem_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
